// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the two-requester SPI flash read arbiter.
package flash_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } req_t;

  // Returned on a watchdog timeout; sliced to DATA_WIDTH (supports up to 64 bits).
  localparam logic [63:0] ERR_DATA = '1;

endpackage

// File: rtl/flash_arb_timeout.sv
// Watchdog for a flash access: fires a one-cycle expire on the TIMEOUT-th running cycle.
module flash_arb_timeout #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count;

  // expire must not depend on clear: clear is derived from the grant, which depends on expire
  assign expire = run && (count == W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else if (run) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/flash_arbiter.sv
// Round-robin arbiter sharing one SPI flash reader between instruction and data read ports.
module flash_arbiter
  import flash_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ready,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_valid,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_ready,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  f_valid,
  output logic [ADDR_WIDTH-1:0] f_addr,
  input  logic                  f_ready,
  input  logic [DATA_WIDTH-1:0] f_rdata,
  output logic                  f_abort,
  output logic                  err
);

  state_t state, state_next;
  req_t   last_grant, last_grant_next;
  logic   grant_i, grant_d;
  logic   busy, expire, timeout, done;
  logic   err_q;
  logic [DATA_WIDTH-1:0] done_data;

  assign busy    = (state != IDLE);
  assign timeout = busy && expire && !f_ready;
  assign done    = busy && (f_ready || expire);

  flash_arb_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (grant_i || grant_d || f_ready),
    .run   (busy),
    .expire(expire)
  );

  // A finishing owner hands straight over to a waiting peer, which also enforces fairness.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    grant_i         = 1'b0;
    grant_d         = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid && (!d_valid || last_grant == REQ_D)) begin
          grant_i = 1'b1;
        end else if (d_valid) begin
          grant_d = 1'b1;
        end
      end
      BUSY_I: begin
        if (done) begin
          if (d_valid) grant_d = 1'b1;
          else         state_next = IDLE;
        end
      end
      BUSY_D: begin
        if (done) begin
          if (i_valid) grant_i = 1'b1;
          else         state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (grant_i) begin
      state_next      = BUSY_I;
      last_grant_next = REQ_I;
    end else if (grant_d) begin
      state_next      = BUSY_D;
      last_grant_next = REQ_D;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= REQ_D;
      f_addr     <= '0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      if (grant_i)      f_addr <= i_addr;
      else if (grant_d) f_addr <= d_addr;
      if (timeout)      err_q  <= 1'b1;
    end
  end

  assign done_data = f_ready ? f_rdata : ERR_DATA[DATA_WIDTH-1:0];
  assign i_ready   = (state == BUSY_I) && done;
  assign d_ready   = (state == BUSY_D) && done;
  assign i_rdata   = i_ready ? done_data : '0;
  assign d_rdata   = d_ready ? done_data : '0;
  assign f_valid   = busy;
  assign f_abort   = timeout;
  assign err       = err_q || timeout;

endmodule

// File: tb/tb_flash_arbiter.sv
// Self-checking bench: table vectors, directed corner sequences and random traffic vs a model.
module tb_flash_arbiter;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_valid = 1'b0, d_valid = 1'b0, f_ready = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] f_rdata = '0;
  logic          i_ready, d_ready, f_valid, f_abort, err;
  logic [DW-1:0] i_rdata, d_rdata;
  logic [AW-1:0] f_addr;

  int n_checks = 0;
  int n_errors = 0;

  flash_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_addr(d_addr), .d_ready(d_ready), .d_rdata(d_rdata),
    .f_valid(f_valid), .f_addr(f_addr), .f_ready(f_ready), .f_rdata(f_rdata),
    .f_abort(f_abort), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] stopped by time limit");
  end

  // Reference model: who owns the flash (0 none, 1 I, 2 D), who was granted last,
  // latched address, busy cycles elapsed in this access, sticky error.
  int          m_owner, m_last, m_wait;
  logic [AW-1:0] m_addr;
  bit          m_err;
  bit          e_fv, e_ir, e_dr, e_abort, e_err;
  logic [DW-1:0] e_ird, e_drd;
  bit          prev_ir, prev_dr;
  int          ready_log[$];

  typedef struct {
    logic iv; logic [AW-1:0] ia; logic dv; logic [AW-1:0] da; logic fr; logic [DW-1:0] fd;
    logic e_fv; logic [AW-1:0] e_faddr; logic e_ir; logic [DW-1:0] e_ird; logic e_dr;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_owner = 0; m_last = 2; m_wait = 0; m_addr = '0; m_err = 0;
    prev_ir = 0; prev_dr = 0;
  endtask

  task automatic modelEval();
    bit busy, fin_data, fin_to;
    busy     = (m_owner != 0);
    fin_data = busy && f_ready;
    fin_to   = busy && !f_ready && (m_wait + 1 == TO);
    e_fv    = busy;
    e_ir    = (m_owner == 1) && (fin_data || fin_to);
    e_dr    = (m_owner == 2) && (fin_data || fin_to);
    e_ird   = e_ir ? (fin_data ? f_rdata : {DW{1'b1}}) : '0;
    e_drd   = e_dr ? (fin_data ? f_rdata : {DW{1'b1}}) : '0;
    e_abort = fin_to;
    e_err   = m_err || fin_to;
  endtask

  task automatic modelAdvance();
    bit fin;
    int nxt, other;
    fin   = e_ir || e_dr;
    m_err = e_err;
    if (m_owner == 0) begin
      if (i_valid && d_valid) nxt = (m_last == 1) ? 2 : 1;
      else if (i_valid)       nxt = 1;
      else if (d_valid)       nxt = 2;
      else                    nxt = 0;
    end else if (fin) begin
      other = 3 - m_owner;
      nxt = ((other == 1 && i_valid) || (other == 2 && d_valid)) ? other : 0;
    end else begin
      nxt = m_owner;
    end
    if ((m_owner == 0 || fin) && nxt != 0) begin
      m_owner = nxt; m_last = nxt; m_wait = 0;
      m_addr  = (nxt == 1) ? i_addr : d_addr;
    end else if (fin) begin
      m_owner = 0; m_wait = 0;
    end else if (m_owner != 0) begin
      m_wait++;
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [AW-1:0] ia, input logic dv,
                               input logic [AW-1:0] da, input logic fr, input logic [DW-1:0] fd);
    i_valid = iv; i_addr = ia; d_valid = dv; d_addr = da; f_ready = fr; f_rdata = fd;
  endtask

  task automatic checkOutput();
    modelEval();
    check("f_valid", f_valid, e_fv);
    check("f_addr", f_addr, m_addr);
    check("f_abort", f_abort, e_abort);
    check("i_ready", i_ready, e_ir);
    check("i_rdata", i_rdata, e_ird);
    check("d_ready", d_ready, e_dr);
    check("d_rdata", d_rdata, e_drd);
    check("err", err, e_err);
    if (i_ready) ready_log.push_back(1);
    if (d_ready) ready_log.push_back(2);
    prev_ir = e_ir; prev_dr = e_dr;
    modelAdvance();
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic nextCycle();
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
    #2;
    check("rst_f_valid", f_valid, 0);
    check("rst_f_addr", f_addr, 0);
    check("rst_f_abort", f_abort, 0);
    check("rst_i_ready", i_ready, 0);
    check("rst_d_ready", d_ready, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_err", err, 0);
    #2;
    reset = 1'b0;
    modelReset();
    nextCycle();
  endtask

  initial begin
    int exp_order[6];
    logic [AW-1:0] ia, da;
    bit iv, dv;

    vecs[0] = '{1'b1, 24'h010000, 1'b0, 24'h0, 1'b0, 32'h0, 1'b0, 24'h000000, 1'b0, 32'h0, 1'b0};
    vecs[1] = '{1'b1, 24'h010000, 1'b0, 24'h0, 1'b0, 32'h0, 1'b1, 24'h010000, 1'b0, 32'h0, 1'b0};
    vecs[2] = vecs[1];
    vecs[3] = vecs[1];
    vecs[4] = vecs[1];
    vecs[5] = '{1'b1, 24'h010000, 1'b0, 24'h0, 1'b1, 32'hDEADBEEF, 1'b1, 24'h010000, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[6] = '{1'b0, 24'h010000, 1'b0, 24'h0, 1'b0, 32'h0, 1'b0, 24'h010000, 1'b0, 32'h0, 1'b0};

    #1;
    doReset();

    // I-only read, table driven
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].ia, vecs[i].dv, vecs[i].da, vecs[i].fr, vecs[i].fd);
      settle();
      check($sformatf("vec%0d_f_valid", i), f_valid, vecs[i].e_fv);
      check($sformatf("vec%0d_f_addr", i), f_addr, vecs[i].e_faddr);
      check($sformatf("vec%0d_i_ready", i), i_ready, vecs[i].e_ir);
      check($sformatf("vec%0d_i_rdata", i), i_rdata, vecs[i].e_ird);
      check($sformatf("vec%0d_d_ready", i), d_ready, vecs[i].e_dr);
      checkOutput();
      nextCycle();
    end

    // Contention right after reset: I first, D back-to-back
    doReset();
    applyStimulus(1'b1, 24'h000100, 1'b1, 24'h000200, 1'b0, '0);
    settle(); check("cont_idle_f_valid", f_valid, 0); checkOutput(); nextCycle();
    settle(); check("cont_grant_i_addr", f_addr, 24'h000100); checkOutput(); nextCycle();
    applyStimulus(1'b1, 24'h000100, 1'b1, 24'h000200, 1'b1, 32'hAAAA5555);
    settle(); check("cont_i_ready", i_ready, 1); check("cont_d_ready_lo", d_ready, 0);
    checkOutput(); nextCycle();
    applyStimulus(1'b0, 24'h000100, 1'b1, 24'h000200, 1'b0, '0);
    settle(); check("cont_b2b_f_valid", f_valid, 1); check("cont_b2b_f_addr", f_addr, 24'h000200);
    checkOutput(); nextCycle();
    applyStimulus(1'b0, 24'h000100, 1'b1, 24'h000200, 1'b1, 32'h0BADF00D);
    settle(); check("cont_d_ready", d_ready, 1); check("cont_i_ready_lo", i_ready, 0);
    checkOutput(); nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
    settle(); check("cont_after_f_valid", f_valid, 0); checkOutput(); nextCycle();

    // Fairness: both requesters permanently busy
    doReset();
    ready_log.delete();
    ia = 24'h001000; da = 24'h002000;
    for (int k = 0; k < 200 && ready_log.size() < 6; k++) begin
      if (prev_ir) ia = ia + 24'd4;
      if (prev_dr) da = da + 24'd4;
      applyStimulus(1'b1, ia, 1'b1, da, (k % 3) == 2, DW'($urandom));
      settle(); checkOutput(); nextCycle();
    end
    check("fair_count", ready_log.size(), 6);
    exp_order = '{1, 2, 1, 2, 1, 2};
    for (int g = 0; g < 6 && g < ready_log.size(); g++)
      check($sformatf("fair_order%0d", g), ready_log[g], exp_order[g]);

    // Timeout on D with no f_ready; err stays sticky
    doReset();
    for (int c = 0; c <= 8; c++) begin
      applyStimulus(1'b0, '0, 1'b1, 24'h00ABCD, 1'b0, '0);
      settle();
      if (c == 7) begin
        check("to_pre_d_ready", d_ready, 0);
        check("to_pre_err", err, 0);
      end
      if (c == 8) begin
        check("to_d_ready", d_ready, 1);
        check("to_d_rdata", d_rdata, 32'hFFFFFFFF);
        check("to_f_abort", f_abort, 1);
        check("to_err", err, 1);
      end
      checkOutput(); nextCycle();
    end
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
    settle(); check("to_after_f_valid", f_valid, 0); checkOutput(); nextCycle();
    for (int c = 0; c < 100; c++) begin
      settle(); checkOutput(); nextCycle();
    end
    settle(); check("to_err_sticky", err, 1); checkOutput(); nextCycle();

    // f_ready on the expiry cycle wins
    doReset();
    for (int c = 0; c <= 8; c++) begin
      applyStimulus(1'b1, 24'h000040, 1'b0, '0, c == 8, 32'h12345678);
      settle();
      if (c == 8) begin
        check("coin_i_ready", i_ready, 1);
        check("coin_i_rdata", i_rdata, 32'h12345678);
        check("coin_f_abort", f_abort, 0);
        check("coin_err", err, 0);
      end
      checkOutput(); nextCycle();
    end
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
    settle(); check("coin_err_after", err, 0); checkOutput(); nextCycle();

    // Reset in the middle of an I access
    doReset();
    applyStimulus(1'b1, 24'h000080, 1'b0, '0, 1'b0, '0);
    settle(); checkOutput(); nextCycle();
    settle(); check("rmid_busy", f_valid, 1); checkOutput(); nextCycle();
    applyStimulus(1'b1, 24'h000080, 1'b0, '0, 1'b1, 32'hCAFE0001);
    #2;
    reset = 1'b1;
    #1;
    check("rmid_f_valid", f_valid, 0);
    check("rmid_i_ready", i_ready, 0);
    check("rmid_f_abort", f_abort, 0);
    applyStimulus(1'b0, '0, 1'b1, 24'h000300, 1'b0, '0);
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput(); nextCycle();
    settle();
    check("rmid_d_grant", f_valid, 1);
    check("rmid_d_addr", f_addr, 24'h000300);
    checkOutput(); nextCycle();
    applyStimulus(1'b0, '0, 1'b1, 24'h000300, 1'b1, 32'h5A5A5A5A);
    settle(); check("rmid_d_ready", d_ready, 1); checkOutput(); nextCycle();

    // Random protocol-abiding traffic against the model
    doReset();
    iv = 0; dv = 0; ia = '0; da = '0;
    for (int c = 0; c < 1500; c++) begin
      if (prev_ir) iv = ($urandom_range(0, 3) == 0);
      else if (!iv) iv = ($urandom_range(0, 2) == 0);
      else if (m_owner == 1 && $urandom_range(0, 19) == 0) iv = 0;
      if (prev_ir || (!i_valid && iv)) ia = AW'($urandom);
      if (prev_dr) dv = ($urandom_range(0, 3) == 0);
      else if (!dv) dv = ($urandom_range(0, 2) == 0);
      else if (m_owner == 2 && $urandom_range(0, 19) == 0) dv = 0;
      if (prev_dr || (!d_valid && dv)) da = AW'($urandom);
      applyStimulus(iv, ia, dv, da,
                    (m_owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0),
                    DW'($urandom));
      settle(); checkOutput(); nextCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/flash_arbiter.md
FLASH_ARBITER -- requirements
Module: flash_arbiter

Interface
REQ-001 The block SHALL provide parameter ADDR_WIDTH, default 24, flash byte-address width.
REQ-002 The block SHALL provide parameter DATA_WIDTH, default 32, read-word width.
REQ-003 The block SHALL provide parameter TIMEOUT, default 1023, the maximum number of cycles to wait for f_ready.
REQ-004 The block SHALL provide these ports, one clock, with asynchronous active-high reset:
  clk  in  1  system clock (post-PLL)
  reset  in  1  asynchronous, active-high
  i_valid  in  1  instruction-fetch read request
  i_addr  in  ADDR_WIDTH  instruction-fetch address
  i_ready  out  1  instruction read complete (1-cycle pulse)
  i_rdata  out  DATA_WIDTH  instruction read data, valid with i_ready
  d_valid  in  1  data read request
  d_addr  in  ADDR_WIDTH  data address
  d_ready  out  1  data read complete (1-cycle pulse)
  d_rdata  out  DATA_WIDTH  data read data, valid with d_ready
  f_valid  out  1  request to shared SPI flash reader
  f_addr  out  ADDR_WIDTH  latched address to flash reader
  f_ready  in  1  flash reader word complete
  f_rdata  in  DATA_WIDTH  flash reader data
  f_abort  out  1  1-cycle pulse cancelling the current flash access
  err  out  1  sticky timeout flag

Function
REQ-005 States SHALL be IDLE, BUSY_I and BUSY_D.
REQ-006 In IDLE, if exactly one of i_valid or d_valid is high, the block SHALL move to the matching BUSY state on the next edge.
REQ-007 If both requests are high in IDLE, the block SHALL grant the requester that is not last_grant (round-robin).
REQ-008 last_grant SHALL update on every grant.
REQ-009 In a BUSY state, f_valid SHALL be 1 and f_addr SHALL hold the granted address, latched at the grant edge.
REQ-010 Latency: a request seen in IDLE at cycle N SHALL produce f_valid at cycle N+1.
REQ-011 In BUSY_x, when f_ready is high, x_ready SHALL be 1 and x_rdata SHALL equal f_rdata, combinationally and in the same cycle.
REQ-012 The other requester's ready SHALL be 0 whenever it is not the granted requester.
REQ-013 On completion, if the other requester's valid is high, the block SHALL move directly to the other BUSY state (back-to-back, no IDLE cycle), with its address latched at that edge.
REQ-014 If the other requester is idle on completion, the block SHALL return to IDLE.
REQ-015 A completing requester that immediately re-requests SHALL NOT be re-granted while the other requester is waiting.
REQ-016 Requesters SHALL hold valid and addr stable until ready.
REQ-017 If valid drops mid-access, the block SHALL still complete the access and pulse ready.
REQ-018 A watchdog SHALL count the cycles spent in BUSY without f_ready.
REQ-019 When the watchdog reaches TIMEOUT, the block SHALL, in that cycle: assert x_ready with x_rdata equal to ERR_DATA (all ones), pulse f_abort, set err, and clear the watchdog count.
REQ-020 After a timeout, next-state selection SHALL be the same as for a normal completion.
REQ-021 The watchdog SHALL clear on every grant and on every f_ready.
REQ-022 If f_ready and the timeout coincide, f_ready SHALL take precedence: normal data is returned, with no abort and no err.
REQ-023 f_valid SHALL be 0 in the cycle after f_ready or f_abort unless a back-to-back grant occurs.
REQ-024 err SHALL be cleared only by reset.

Reset
REQ-025 On reset assertion, asynchronously: state = IDLE, f_valid = 0, f_addr = 0, f_abort = 0, i_ready = d_ready = 0, i_rdata = d_rdata = 0, err = 0, watchdog = 0, last_grant = D (so I wins the first contention).
REQ-026 Reset asserted mid-access SHALL abandon the access without issuing f_abort.
REQ-027 After reset, the flash reader SHALL be reset by the same reset signal.

Structure
REQ-028 The package flash_arb_pkg SHALL hold the state enum (IDLE, BUSY_I, BUSY_D), the requester enum (REQ_I, REQ_D) and the ERR_DATA constant.
REQ-029 The watchdog SHALL be a sub-module flash_arb_timeout with inputs clk, reset, clear and run, and a 1-cycle expire output, parameterized by TIMEOUT, with width $clog2(TIMEOUT+1).
REQ-030 All other logic SHALL reside in flash_arbiter.

Verification
REQ-031 I-only: i_valid at cycle 0 with i_addr=24'h010000, f_ready at cycle 5 with f_rdata=32'hDEADBEEF -> f_valid cycles 1-5, f_addr=24'h010000, i_ready pulse at cycle 5 with i_rdata=32'hDEADBEEF, d_ready never asserted.
REQ-032 Contention after reset: i_valid and d_valid both high at cycle 0 -> I granted first; D granted on the edge after I completes, with no IDLE cycle and f_addr=d_addr.
REQ-033 Fairness: both requesters held high for 6 transactions -> grants alternate I,D,I,D,I,D.
REQ-034 Timeout with TIMEOUT=8: d_valid high, f_ready never asserted -> at the 8th BUSY cycle d_ready=1, d_rdata=32'hFFFFFFFF, f_abort=1, err=1; err still 1 after 100 cycles.
REQ-035 Coincident f_ready and expiry -> real data returned, f_abort=0, err=0.
REQ-036 Reset asserted in BUSY_I -> within the same cycle f_valid=0 and i_ready=0; the next request from D is granted first if I is idle.
